// File: rtl/snake_body_if.sv
// Control and status bundle between the game state machine and the snake body engine.
interface snake_body_if;
    logic       Start;
    logic       Run;
    logic       Tick;
    logic [1:0] Dir;
    logic [3:0] Food_X;
    logic [3:0] Food_Y;
    logic [3:0] Query_X;
    logic [3:0] Query_Y;
    logic       Cell_Snake;
    logic [3:0] Head_X;
    logic [3:0] Head_Y;
    logic [7:0] Length;
    logic       Collision;
    logic       Eat;
    logic       Busy;

    modport master (
        output Start, Run, Tick, Dir, Food_X, Food_Y, Query_X, Query_Y,
        input  Cell_Snake, Head_X, Head_Y, Length, Collision, Eat, Busy
    );

    modport slave (
        input  Start, Run, Tick, Dir, Food_X, Food_Y, Query_X, Query_Y,
        output Cell_Snake, Head_X, Head_Y, Length, Collision, Eat, Busy
    );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body on a 15x15 grid: circular coordinate buffer plus occupancy bitmap,
// advancing one cell per accepted Tick with wall/self collision and growth on food.
module snake_body_engine #(
    parameter int GRID_W   = 15,
    parameter int GRID_H   = 15,
    parameter int INIT_LEN = 3
) (
    input logic          Clk,
    input logic          Reset,
    snake_body_if.slave  bus
);

    localparam int         CELLS     = GRID_W * GRID_H;
    localparam logic [3:0] LAST_X    = 4'(GRID_W - 1);
    localparam logic [3:0] LAST_Y    = 4'(GRID_H - 1);
    localparam logic [3:0] INIT_LAST = 4'(INIT_LEN - 1);
    localparam logic [3:0] INIT_X0   = 4'(8 - INIT_LEN);
    localparam logic [3:0] INIT_Y    = 4'd7;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CHECK,
        S_HEAD,
        S_TAIL,
        S_DEAD
    } state_t;

    state_t state, next_state;

    logic [3:0]       init_cnt;
    logic [7:0]       head_ptr;
    logic [7:0]       tail_ptr;
    logic [1:0]       cur_dir;
    logic [3:0]       head_x;
    logic [3:0]       head_y;
    logic [7:0]       length;
    logic             collision;
    logic             eat;
    logic             grow_q;
    logic [CELLS-1:0] bitmap;
    logic [7:0]       body_buf [256];

    logic       buf_we;
    logic [7:0] buf_waddr;
    logic [7:0] buf_wdata;

    logic [4:0] nx;
    logic [4:0] ny;
    logic       wall_hit;
    logic       grow;
    logic       on_tail;
    logic       self_hit;
    logic       hit;
    logic       accept;
    logic [7:0] next_idx;
    logic [7:0] tail_cell;
    logic [7:0] tail_idx;
    logic [3:0] init_x;
    logic [7:0] init_idx;

    function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return 8'({4'b0, y} * 8'(GRID_W) + {4'b0, x});
    endfunction

    // Next head in 5 bits: a step below zero wraps to 31, so one upper-bound test covers both walls.
    always_comb begin
        nx = {1'b0, head_x};
        ny = {1'b0, head_y};
        case (cur_dir)
            DIR_UP:    ny = {1'b0, head_y} - 5'd1;
            DIR_RIGHT: nx = {1'b0, head_x} + 5'd1;
            DIR_DOWN:  ny = {1'b0, head_y} + 5'd1;
            default:   nx = {1'b0, head_x} - 5'd1;
        endcase
    end

    assign tail_cell = body_buf[tail_ptr];
    assign tail_idx  = cell_idx(tail_cell[7:4], tail_cell[3:0]);
    assign next_idx  = cell_idx(nx[3:0], ny[3:0]);
    assign wall_hit  = (nx > {1'b0, LAST_X}) || (ny > {1'b0, LAST_Y});
    assign grow      = (nx[3:0] == bus.Food_X) && (ny[3:0] == bus.Food_Y);
    assign on_tail   = (nx[3:0] == tail_cell[7:4]) && (ny[3:0] == tail_cell[3:0]);
    assign self_hit  = bitmap[next_idx] && !(on_tail && !grow);
    assign hit       = wall_hit || self_hit;

    assign init_x   = INIT_X0 + init_cnt;
    assign init_idx = cell_idx(init_x, INIT_Y);

    assign accept = (state == S_IDLE) && bus.Tick && bus.Run && !collision
                    && (length < 8'(CELLS));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_INIT;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        next_state = state;
        buf_we     = 1'b0;
        buf_waddr  = head_ptr + 8'd1;
        buf_wdata  = {nx[3:0], ny[3:0]};
        if (bus.Start) begin
            next_state = S_INIT;
        end else begin
            case (state)
                S_INIT: begin
                    buf_we    = 1'b1;
                    buf_waddr = {4'b0, init_cnt};
                    buf_wdata = {init_x, INIT_Y};
                    if (init_cnt == INIT_LAST) next_state = S_IDLE;
                end
                S_IDLE:  if (accept) next_state = S_CHECK;
                S_CHECK: next_state = hit ? S_DEAD : S_HEAD;
                S_HEAD: begin
                    buf_we     = 1'b1;
                    next_state = grow_q ? S_IDLE : S_TAIL;
                end
                S_TAIL:  next_state = S_IDLE;
                S_DEAD:  next_state = S_DEAD;
                default: next_state = S_INIT;
            endcase
        end
    end

    // NOTE: the coordinate RAM has no reset; INIT rewrites every entry that is ever read.
    always_ff @(posedge Clk) begin
        if (buf_we) body_buf[buf_waddr] <= buf_wdata;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            init_cnt  <= '0;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            cur_dir   <= DIR_RIGHT;
            head_x    <= 4'd7;
            head_y    <= 4'd7;
            length    <= '0;
            collision <= 1'b0;
            eat       <= 1'b0;
            grow_q    <= 1'b0;
            bitmap    <= '0;
        end else begin
            eat <= 1'b0;
            if (bus.Start) begin
                init_cnt  <= '0;
                collision <= 1'b0;
                length    <= '0;
                head_x    <= 4'd7;
                head_y    <= 4'd7;
            end else begin
                case (state)
                    S_INIT: begin
                        if (init_cnt == 4'd0) bitmap <= '0;
                        bitmap[init_idx] <= 1'b1;
                        init_cnt         <= init_cnt + 4'd1;
                        if (init_cnt == INIT_LAST) begin
                            head_ptr <= 8'(INIT_LEN - 1);
                            tail_ptr <= '0;
                            cur_dir  <= DIR_RIGHT;
                            length   <= 8'(INIT_LEN);
                            head_x   <= init_x;
                            head_y   <= INIT_Y;
                        end
                    end
                    S_IDLE: begin
                        if (accept && (bus.Dir != (cur_dir ^ 2'b10))) cur_dir <= bus.Dir;
                    end
                    S_CHECK: begin
                        grow_q <= grow;
                        if (hit) collision <= 1'b1;
                    end
                    S_HEAD: begin
                        head_ptr         <= head_ptr + 8'd1;
                        bitmap[next_idx] <= 1'b1;
                        head_x           <= nx[3:0];
                        head_y           <= ny[3:0];
                        if (grow_q) begin
                            eat <= 1'b1;
                            if (length < 8'(CELLS)) length <= length + 8'd1;
                        end
                    end
                    S_TAIL: begin
                        // Tail-chase: the old tail cell is now the head, so its bit stays set.
                        if (tail_cell != {head_x, head_y}) bitmap[tail_idx] <= 1'b0;
                        tail_ptr <= tail_ptr + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.Cell_Snake = (bus.Query_X <= LAST_X && bus.Query_Y <= LAST_Y)
                            ? bitmap[cell_idx(bus.Query_X, bus.Query_Y)] : 1'b0;
    assign bus.Head_X     = head_x;
    assign bus.Head_Y     = head_y;
    assign bus.Length     = length;
    assign bus.Collision  = collision;
    assign bus.Eat        = eat;
    assign bus.Busy       = (state != S_IDLE);

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: init, move, grow, tail chase, walls, reversal, tick filtering.
module tb_snake_body_engine;

    logic Clk = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;

    snake_body_if bus ();

    snake_body_engine dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic query(input logic [3:0] x, input logic [3:0] y);
        bus.Query_X = x;
        bus.Query_Y = y;
        #1;
    endtask

    // One Tick pulse; returns cycles until Busy drops (-1 on timeout) and Eat pulses seen.
    task automatic do_tick(input logic [1:0] d, output int busy_c, output int eat_c);
        @(negedge Clk);
        bus.Dir  = d;
        bus.Tick = 1'b1;
        @(negedge Clk);
        bus.Tick = 1'b0;
        busy_c = -1;
        eat_c  = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.Eat) eat_c++;
            if (!bus.Busy) begin
                busy_c = c;
                break;
            end
            @(negedge Clk);
        end
    endtask

    // Start pulse; returns Collision one cycle after it and whether INIT finished in time.
    task automatic do_start(output logic coll_after, output logic done);
        @(negedge Clk);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start  = 1'b0;
        coll_after = bus.Collision;
        done       = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!bus.Busy) begin
                done = 1'b1;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_reset;
        logic [3:0] qx [4] = '{4'd5, 4'd6, 4'd7, 4'd8};
        logic       qe [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        checks++; if (bus.Length !== 8'd0) begin failures++; $display("FAIL reset_length: got %0d exp 0", bus.Length); end
        checks++; if (bus.Busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b exp 1", bus.Busy); end
        checks++; if (bus.Collision !== 1'b0 || bus.Eat !== 1'b0) begin failures++; $display("FAIL reset_flags: coll %b eat %b exp 0 0", bus.Collision, bus.Eat); end
        checks++; if (bus.Head_X !== 4'd7 || bus.Head_Y !== 4'd7) begin failures++; $display("FAIL reset_head: got (%0d,%0d) exp (7,7)", bus.Head_X, bus.Head_Y); end
        query(4'd6, 4'd7);
        checks++; if (bus.Cell_Snake !== 1'b0) begin failures++; $display("FAIL reset_bitmap: got %b exp 0", bus.Cell_Snake); end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if (bus.Busy !== 1'b1) begin failures++; $display("FAIL init_busy_c2: got %b exp 1", bus.Busy); end
        @(negedge Clk);
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL init_busy_c3: got %b exp 0", bus.Busy); end
        checks++; if (bus.Length !== 8'd3) begin failures++; $display("FAIL init_length: got %0d exp 3", bus.Length); end
        checks++; if (bus.Head_X !== 4'd7 || bus.Head_Y !== 4'd7) begin failures++; $display("FAIL init_head: got (%0d,%0d) exp (7,7)", bus.Head_X, bus.Head_Y); end
        for (int i = 0; i < 4; i++) begin
            query(qx[i], 4'd7);
            checks++; if (bus.Cell_Snake !== qe[i]) begin failures++; $display("FAIL init_cell_%0d_7: got %b exp %b", qx[i], bus.Cell_Snake, qe[i]); end
        end
    endtask

    task automatic test_move;
        int bc, ec;
        do_tick(2'b01, bc, ec);
        checks++; if (bc !== 3) begin failures++; $display("FAIL move_busy_cycles: got %0d exp 3", bc); end
        checks++; if (ec !== 0) begin failures++; $display("FAIL move_eat: got %0d exp 0", ec); end
        checks++; if (bus.Head_X !== 4'd8 || bus.Head_Y !== 4'd7) begin failures++; $display("FAIL move_head: got (%0d,%0d) exp (8,7)", bus.Head_X, bus.Head_Y); end
        checks++; if (bus.Length !== 8'd3) begin failures++; $display("FAIL move_length: got %0d exp 3", bus.Length); end
        query(4'd5, 4'd7);
        checks++; if (bus.Cell_Snake !== 1'b0) begin failures++; $display("FAIL move_old_tail: got %b exp 0", bus.Cell_Snake); end
        query(4'd8, 4'd7);
        checks++; if (bus.Cell_Snake !== 1'b1) begin failures++; $display("FAIL move_new_head: got %b exp 1", bus.Cell_Snake); end
    endtask

    task automatic test_grow;
        int bc, ec;
        logic ca, dn;
        do_start(ca, dn);
        checks++; if (dn !== 1'b1) begin failures++; $display("FAIL grow_start_done: got %b exp 1", dn); end
        bus.Food_X = 4'd8;
        bus.Food_Y = 4'd7;
        do_tick(2'b01, bc, ec);
        bus.Food_X = 4'd0;
        bus.Food_Y = 4'd0;
        checks++; if (bc !== 2) begin failures++; $display("FAIL grow_busy_cycles: got %0d exp 2", bc); end
        checks++; if (ec !== 1) begin failures++; $display("FAIL grow_eat: got %0d exp 1", ec); end
        checks++; if (bus.Length !== 8'd4) begin failures++; $display("FAIL grow_length: got %0d exp 4", bus.Length); end
        @(negedge Clk);
        checks++; if (bus.Eat !== 1'b0) begin failures++; $display("FAIL grow_eat_pulse: got %b exp 0", bus.Eat); end
        query(4'd5, 4'd7);
        checks++; if (bus.Cell_Snake !== 1'b1) begin failures++; $display("FAIL grow_tail_kept: got %b exp 1", bus.Cell_Snake); end
    endtask

    // Continues from the grown body (5,7)..(8,7): down, left, then up into the vacating tail.
    task automatic test_tail_chase;
        int bc, ec, cc;
        logic [3:0] bx [4] = '{4'd8, 4'd8, 4'd7, 4'd7};
        logic [3:0] by [4] = '{4'd7, 4'd8, 4'd8, 4'd7};
        do_tick(2'b10, bc, ec);
        do_tick(2'b11, bc, ec);
        checks++; if (bus.Head_X !== 4'd7 || bus.Head_Y !== 4'd8) begin failures++; $display("FAIL loop_head: got (%0d,%0d) exp (7,8)", bus.Head_X, bus.Head_Y); end
        query(4'd6, 4'd7);
        checks++; if (bus.Cell_Snake !== 1'b0) begin failures++; $display("FAIL loop_tail_cleared: got %b exp 0", bus.Cell_Snake); end
        do_tick(2'b00, bc, ec);
        checks++; if (bc !== 3) begin failures++; $display("FAIL chase_busy_cycles: got %0d exp 3", bc); end
        checks++; if (bus.Collision !== 1'b0) begin failures++; $display("FAIL chase_collision: got %b exp 0", bus.Collision); end
        checks++; if (bus.Length !== 8'd4) begin failures++; $display("FAIL chase_length: got %0d exp 4", bus.Length); end
        checks++; if (bus.Head_X !== 4'd7 || bus.Head_Y !== 4'd7) begin failures++; $display("FAIL chase_head: got (%0d,%0d) exp (7,7)", bus.Head_X, bus.Head_Y); end
        for (int i = 0; i < 4; i++) begin
            query(bx[i], by[i]);
            checks++; if (bus.Cell_Snake !== 1'b1) begin failures++; $display("FAIL chase_cell_%0d_%0d: got %b exp 1", bx[i], by[i], bus.Cell_Snake); end
        end
        // Same kind of move, but food on the tail cell means the tail stays: self hit.
        bus.Food_X = 4'd8;
        bus.Food_Y = 4'd7;
        @(negedge Clk);
        bus.Dir  = 2'b01;
        bus.Tick = 1'b1;
        @(negedge Clk);
        bus.Tick = 1'b0;
        cc = -1;
        for (int c = 0; c < 8; c++) begin
            if (bus.Collision) begin
                cc = c;
                break;
            end
            @(negedge Clk);
        end
        bus.Food_X = 4'd0;
        bus.Food_Y = 4'd0;
        checks++; if (cc !== 1) begin failures++; $display("FAIL food_tail_collision_cycle: got %0d exp 1", cc); end
        checks++; if (bus.Head_X !== 4'd7 || bus.Head_Y !== 4'd7) begin failures++; $display("FAIL food_tail_head: got (%0d,%0d) exp (7,7)", bus.Head_X, bus.Head_Y); end
        checks++; if (bus.Length !== 8'd4) begin failures++; $display("FAIL food_tail_length: got %0d exp 4", bus.Length); end
    endtask

    task automatic test_wall;
        int bc, ec, cc;
        logic ca, dn;
        do_start(ca, dn);
        checks++; if (ca !== 1'b0) begin failures++; $display("FAIL wall_start_clears: got %b exp 0", ca); end
        checks++; if (dn !== 1'b1 || bus.Length !== 8'd3) begin failures++; $display("FAIL wall_start_init: done %b len %0d exp 1 3", dn, bus.Length); end
        for (int i = 0; i < 7; i++) begin
            do_tick(2'b01, bc, ec);
            checks++; if (bc !== 3) begin failures++; $display("FAIL wall_step%0d_busy: got %0d exp 3", i, bc); end
        end
        checks++; if (bus.Head_X !== 4'd14 || bus.Head_Y !== 4'd7) begin failures++; $display("FAIL wall_edge_head: got (%0d,%0d) exp (14,7)", bus.Head_X, bus.Head_Y); end
        @(negedge Clk);
        bus.Tick = 1'b1;
        @(negedge Clk);
        bus.Tick = 1'b0;
        cc = -1;
        for (int c = 0; c < 8; c++) begin
            if (bus.Collision) begin
                cc = c;
                break;
            end
            @(negedge Clk);
        end
        checks++; if (cc !== 1) begin failures++; $display("FAIL wall_collision_cycle: got %0d exp 1", cc); end
        bus.Tick = 1'b1;
        repeat (3) @(negedge Clk);
        bus.Tick = 1'b0;
        repeat (3) @(negedge Clk);
        checks++; if (bus.Head_X !== 4'd14 || bus.Head_Y !== 4'd7) begin failures++; $display("FAIL wall_dead_head: got (%0d,%0d) exp (14,7)", bus.Head_X, bus.Head_Y); end
        checks++; if (bus.Collision !== 1'b1 || bus.Busy !== 1'b1) begin failures++; $display("FAIL wall_dead_hold: coll %b busy %b exp 1 1", bus.Collision, bus.Busy); end
        do_start(ca, dn);
        checks++; if (ca !== 1'b0) begin failures++; $display("FAIL wall_restart_coll: got %b exp 0", ca); end
        checks++; if (bus.Length !== 8'd3 || bus.Head_X !== 4'd7) begin failures++; $display("FAIL wall_restart_state: len %0d hx %0d exp 3 7", bus.Length, bus.Head_X); end
    endtask

    task automatic test_reverse;
        int bc, ec;
        do_tick(2'b11, bc, ec);
        checks++; if (bus.Head_X !== 4'd8 || bus.Head_Y !== 4'd7) begin failures++; $display("FAIL reverse_head: got (%0d,%0d) exp (8,7)", bus.Head_X, bus.Head_Y); end
        checks++; if (bus.Collision !== 1'b0) begin failures++; $display("FAIL reverse_collision: got %b exp 0", bus.Collision); end
    endtask

    task automatic test_back_to_back;
        logic ca, dn;
        @(negedge Clk);
        bus.Dir  = 2'b01;
        bus.Tick = 1'b1;
        repeat (3) @(negedge Clk);
        bus.Tick = 1'b0;
        repeat (6) @(negedge Clk);
        checks++; if (bus.Head_X !== 4'd9 || bus.Busy !== 1'b0) begin failures++; $display("FAIL b2b_single_move: hx %0d busy %b exp 9 0", bus.Head_X, bus.Busy); end
        bus.Run  = 1'b0;
        bus.Tick = 1'b1;
        @(negedge Clk);
        bus.Tick = 1'b0;
        repeat (5) @(negedge Clk);
        bus.Run = 1'b1;
        checks++; if (bus.Head_X !== 4'd9 || bus.Busy !== 1'b0) begin failures++; $display("FAIL run_low_ignored: hx %0d busy %b exp 9 0", bus.Head_X, bus.Busy); end
        // Start and Tick together: Start wins and the body comes back at (7,7).
        @(negedge Clk);
        bus.Tick  = 1'b1;
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Tick  = 1'b0;
        bus.Start = 1'b0;
        repeat (5) @(negedge Clk);
        checks++; if (bus.Head_X !== 4'd7 || bus.Length !== 8'd3 || bus.Busy !== 1'b0) begin failures++; $display("FAIL start_wins: hx %0d len %0d busy %b exp 7 3 0", bus.Head_X, bus.Length, bus.Busy); end
        query(4'd15, 4'd7);
        checks++; if (bus.Cell_Snake !== 1'b0) begin failures++; $display("FAIL query_x_range: got %b exp 0", bus.Cell_Snake); end
        query(4'd7, 4'd15);
        checks++; if (bus.Cell_Snake !== 1'b0) begin failures++; $display("FAIL query_y_range: got %b exp 0", bus.Cell_Snake); end
        do_start(ca, dn);
    endtask

    initial begin
        bus.Start   = 1'b0;
        bus.Run     = 1'b1;
        bus.Tick    = 1'b0;
        bus.Dir     = 2'b01;
        bus.Food_X  = 4'd0;
        bus.Food_Y  = 4'd0;
        bus.Query_X = 4'd0;
        bus.Query_Y = 4'd0;
        test_reset;
        test_move;
        test_grow;
        test_tail_chase;
        test_wall;
        test_reverse;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
